// File: rtl/game_net_pkg.sv
// Shared game packet definitions for the tx/rx paths.
// Header, sizes, payload layout, CRC-8 step function.
package game_net_pkg;

  localparam logic [7:0] GAME_PKT_HEADER = 8'hA5;
  localparam int GAME_PKT_BYTES = 8;
  localparam int GAME_PAYLOAD_W = 40;
  localparam logic [7:0] GAME_CRC8_POLY = 8'h07;

  // MSB-first field order; P0 is the top byte.
  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  dir;
    logic [2:0]  stat;
    logic        rst;
    logic [4:0]  pad;
  } game_payload_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_e;

  // One byte of CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8_update(
    input logic [7:0] crc,
    input logic [7:0] data
  );
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ GAME_CRC8_POLY;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/game_state_tx_crc8_byte.sv
// Combinational CRC-8 step over one byte.
// crc_in/data_in -> crc_out.
module crc8_byte
  import game_net_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  assign crc_out = crc8_update(crc_in, data_in);

endmodule

// File: rtl/game_state_tx.sv
// Per-frame local player state packet, sent as dibits.
// Ports: clk/rst, hcount/vcount, player fields, axiov/axiod, busy, seq_num.
module game_state_tx
  import game_net_pkg::*;
#(
  parameter int         TX_H       = 1200,
  parameter int         TX_V       = 800,
  parameter logic [7:0] HEADER     = GAME_PKT_HEADER,
  parameter int         GAP_CYCLES = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [10:0] player_x,
  input  logic [10:0] player_y,
  input  logic [8:0]  player_direction,
  input  logic [2:0]  game_stat,
  input  logic        local_rst,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        busy,
  output logic [7:0]  seq_num
);

  localparam int PKT_W = GAME_PKT_BYTES * 8;
  localparam int PKT_DIBITS = GAME_PKT_BYTES * 4;
  localparam logic [10:0] TX_H_L = TX_H[10:0];
  localparam logic [9:0]  TX_V_L = TX_V[9:0];
  localparam logic [5:0]  LAST_DIB = 6'(PKT_DIBITS);
  // GAP_CYCLES must be at least 1.
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  tx_state_e state_q, state_d;
  logic              axiov_q, axiov_d;
  logic [1:0]        axiod_q, axiod_d;
  logic              busy_q, busy_d;
  logic [7:0]        seq_q, seq_d;
  logic [5:0]        dib_cnt_q, dib_cnt_d;
  logic [15:0]       gap_cnt_q, gap_cnt_d;
  logic [PKT_W-3:0]  sreg_q, sreg_d;

  logic trig;
  logic last_dib;
  logic gap_last;

  game_payload_t              payload_c;
  logic [GAME_PAYLOAD_W-1:0]  p_bits;
  logic [7:0]                 crc_b [0:5];
  logic [7:0]                 crc_c [0:6];
  logic [PKT_W-1:0]           pkt_c;

  assign trig = (hcount == TX_H_L) &&
                (vcount == TX_V_L);
  assign last_dib = (dib_cnt_q == LAST_DIB);
  assign gap_last = (gap_cnt_q == GAP_LAST);

  always_comb begin
    payload_c      = '0;
    payload_c.x    = player_x;
    payload_c.y    = player_y;
    payload_c.dir  = player_direction;
    payload_c.stat = game_stat;
    payload_c.rst  = local_rst;
  end

  assign p_bits = payload_c;

  // CRC covers SEQ then P0..P4; header is excluded.
  assign crc_b[0] = seq_q;
  assign crc_c[0] = 8'h00;

  for (genvar i = 0; i < 5; i++) begin : g_pay
    assign crc_b[i+1] = p_bits[GAME_PAYLOAD_W-1-8*i -: 8];
  end

  for (genvar i = 0; i < 6; i++) begin : g_crc
    crc8_byte u_crc (
      .crc_in  (crc_c[i]),
      .data_in (crc_b[i]),
      .crc_out (crc_c[i+1])
    );
  end

  // Byte 0 sits in the low bits so a right shift
  // sends bytes in order, each LSB dibit first.
  for (genvar i = 0; i < 6; i++) begin : g_pkt
    assign pkt_c[8*(i+1) +: 8] = crc_b[i];
  end
  assign pkt_c[7:0] = HEADER;
  assign pkt_c[PKT_W-1 -: 8] = crc_c[6];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      axiov_q   <= 1'b0;
      axiod_q   <= 2'b00;
      busy_q    <= 1'b0;
      seq_q     <= 8'h00;
      dib_cnt_q <= '0;
      gap_cnt_q <= '0;
      sreg_q    <= '0;
    end else begin
      state_q   <= state_d;
      axiov_q   <= axiov_d;
      axiod_q   <= axiod_d;
      busy_q    <= busy_d;
      seq_q     <= seq_d;
      dib_cnt_q <= dib_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sreg_q    <= sreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == TX_IDLE): if (trig) state_d = TX_SEND;
      (state_q == TX_SEND): if (last_dib) state_d = TX_GAP;
      (state_q == TX_GAP):  if (gap_last) state_d = TX_IDLE;
      default:              state_d = TX_IDLE;
    endcase
  end

  // The first dibit is loaded straight from the packet
  // so it appears the cycle after the trigger.
  always_comb begin
    axiov_d   = 1'b0;
    axiod_d   = 2'b00;
    seq_d     = seq_q;
    dib_cnt_d = dib_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sreg_d    = sreg_q;
    unique case (1'b1)
      (state_q == TX_IDLE): begin
        if (trig) begin
          axiov_d   = 1'b1;
          axiod_d   = pkt_c[1:0];
          sreg_d    = pkt_c[PKT_W-1:2];
          dib_cnt_d = 6'd1;
        end
      end
      (state_q == TX_SEND): begin
        if (last_dib) begin
          seq_d     = seq_q + 8'd1;
          dib_cnt_d = '0;
          gap_cnt_d = '0;
        end else begin
          axiov_d   = 1'b1;
          axiod_d   = sreg_q[1:0];
          sreg_d    = {2'b00, sreg_q[PKT_W-3:2]};
          dib_cnt_d = dib_cnt_q + 6'd1;
        end
      end
      (state_q == TX_GAP): begin
        gap_cnt_d = gap_last ? '0 : gap_cnt_q + 16'd1;
      end
      default: ;
    endcase
    busy_d = (state_d != TX_IDLE);
  end

  assign axiov   = axiov_q;
  assign axiod   = axiod_q;
  assign busy    = busy_q;
  assign seq_num = seq_q;

endmodule
